wrr_fifo_arbiter: RTL and testbench
===================================

// Module: wrr_fifo_arbiter
// PURPOSE
//  Weighted round-robin arbiter. Merges the readout FIFOs (FE data rx, TLU, timestamp/timestamp640 units)
//  into the single 32-bit stream that feeds the SiTCP/USB FIFO.
//  Each source holds the grant for a burst of up to BURST_LIMIT+1 words.
//  HOLD_REQ keeps multi-word packets atomic.
//  Sits between the source FIFOs and the output FIFO, in the BUS_CLK domain.
// PARAMETERS
//  WIDTH    7   number of requesters; index 0 is the lowest round-robin start point
//  DW       32  data word width
//  BURST_W  4   width of each per-source burst-limit field
// PORTS
//  BUS_CLK      in   1            bus clock; all logic is synchronous to it
//  nRST         in   1            asynchronous, active-low reset
//  WRITE_REQ    in   WIDTH        source FIFO not empty (FWFT: DATA_IN is valid while high)
//  HOLD_REQ     in   WIDTH        keep the grant while high, even with WRITE_REQ low
//  DATA_IN      in   WIDTH*DW     concatenated source words; source i at [i*DW +: DW]
//  BURST_LIMIT  in   WIDTH*BURST_W  static config; burst length = value+1 words
//  READ_GRANT   out  WIDTH        pop strobe to source FIFO; one-hot or zero
//  READY_OUT    in   1            output FIFO can accept a word
//  WRITE_OUT    out  1            registered write strobe to the output FIFO
//  DATA_OUT     out  DW           registered data to the output FIFO
// BEHAVIOUR
//  Reset (nRST=0, async):
//   - state=ARB, owner=WIDTH-1, burst_cnt=0
//   - WRITE_OUT=0, DATA_OUT=0, READ_GRANT=0
//  FSM ARB:
//   - pick first i with WRITE_REQ[i], scanning owner+1, owner+2, ... with wrap modulo WIDTH
//   - if found: owner<=i, burst_cnt<=0, ->GRANT; none found -> stay in ARB
//   - always one dead cycle between grants
//  FSM GRANT:
//   - READ_GRANT[owner] = WRITE_REQ[owner] & READY_OUT (combinational); no other bit set
//   - on each pop: DATA_OUT<=DATA_IN[owner], WRITE_OUT<=1 next cycle (latency 1); else WRITE_OUT<=0
//   - burst_cnt increments per pop
//   - release to ARB when:
//     (a) a pop makes burst_cnt == BURST_LIMIT[owner] and HOLD_REQ[owner]=0, or
//     (b) WRITE_REQ[owner]=0 and HOLD_REQ[owner]=0
//   - HOLD_REQ[owner]=1 overrides the burst limit; the grant persists and burst_cnt saturates
//   - WRITE_REQ=0 with HOLD=1: wait in GRANT, issue no pops
//  Backpressure:
//   - READY_OUT=0 suppresses pops immediately
//   - one word may already be in the output register; downstream must absorb 1 word after READY_OUT falls
//  Simultaneous requests:
//   - exactly one owner; round-robin from the last owner guarantees no starvation
//   - worst-case wait = sum over others of (BURST_LIMIT+1 words + 1 cycle), when HOLD_REQ is unused
//  Boundaries:
//   - BURST_LIMIT=0 -> single-word bursts
//   - owner=WIDTH-1 wraps the scan to 0
//   - BURST_LIMIT changes mid-burst take effect on the next compare
//  Reset mid-burst: aborts immediately; no further pop or write. The word in the register is dropped.
// CONFIGURATION
//  WRR_ARB_STAT_EN defined:
//   - adds ports STAT_SEL in [$clog2(WIDTH)] and STAT_CNT out [32]
//   - per-source 32-bit popped-word counters, saturating at 2^32-1, cleared by nRST
//   - STAT_CNT = counter[STAT_SEL], registered, 1-cycle latency
//  WRR_ARB_STAT_EN undefined: no counters, no extra ports; the core arbiter is identical.
// STRUCTURE
//  Shared package monopix_arb_pkg:
//   - state typedef (ARB, GRANT)
//   - DW default
//   - function rr_pick(req, last) returning next index + valid
//  One sub-module: wrr_rr_pick, a combinational rotate-priority-encoder. All else stays in the top level.
// TESTING
//  T1: WRITE_REQ=7'b0000101, all limits 0, READY=1
//      -> grants alternate 0,2,0,2; every pop followed by a dead ARB cycle; WRITE_OUT pulses 1 cycle after each pop
//  T2: source 4 with 20 words, BURST_LIMIT[4]=3, source 1 also requesting
//      -> pattern of 4 words src4, 1 word src1, repeated; no word lost or duplicated
//  T3: HOLD_REQ[3]=1 for a 6-word packet, BURST_LIMIT=0, WRITE_REQ[3] gap of 5 cycles mid-packet
//      -> all 6 words contiguous in order; no other READ_GRANT during the gap
//  T4: READY_OUT toggled 1010... during a burst
//      -> READ_GRANT only in cycles with READY=1; DATA_OUT sequence equals source order; at most 1 word after READY falls
//  T5: nRST pulsed low mid-burst on source 6
//      -> READ_GRANT=0, WRITE_OUT=0 asynchronously; after release, first grant goes to the lowest requesting index (scan starts at 0)
//  T6 (WRR_ARB_STAT_EN): 100 words src0, 37 words src5
//      -> STAT_CNT reads 100 for STAT_SEL=0, 37 for STAT_SEL=5

Source files
------------

// File: rtl/wrr_fifo_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the readout FIFO arbiter.
package monopix_arb_pkg;

  localparam int ARB_DW = 32;
  localparam int RR_MAX = 16;
  localparam int RR_IW  = $clog2(RR_MAX);

  typedef logic [0:0] state_t;
  localparam state_t ST_ARB   = 1'b0;
  localparam state_t ST_GRANT = 1'b1;

  typedef struct packed {
    logic             valid;
    logic [RR_IW-1:0] idx;
  } rr_pick_t;

  // First set bit of req scanning last+1, last+2, ... modulo n (n <= RR_MAX).
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req,
                                       input logic [RR_IW-1:0]  last,
                                       input int                n);
    rr_pick_t p;
    int       j;
    p = '0;
    for (int k = 1; k <= RR_MAX; k++) begin
      j = int'(last) + k;
      if (j >= n) j = j - n;
      if (k <= n && !p.valid && req[j[RR_IW-1:0]]) begin
        p.valid = 1'b1;
        p.idx   = j[RR_IW-1:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/wrr_fifo_arbiter_if.sv
// Source-FIFO / output-FIFO handshake bundle of the arbiter.
interface wrr_fifo_arbiter_if import monopix_arb_pkg::*; #(
  parameter int WIDTH   = 7,
  parameter int DW      = ARB_DW,
  parameter int BURST_W = 4
);
  logic [WIDTH-1:0]              WRITE_REQ;
  logic [WIDTH-1:0]              HOLD_REQ;
  logic [WIDTH-1:0][DW-1:0]      DATA_IN;
  logic [WIDTH-1:0][BURST_W-1:0] BURST_LIMIT;
  logic [WIDTH-1:0]              READ_GRANT;
  logic                          READY_OUT;
  logic                          WRITE_OUT;
  logic [DW-1:0]                 DATA_OUT;

  modport master (
    input  WRITE_REQ, HOLD_REQ, DATA_IN, BURST_LIMIT, READY_OUT,
    output READ_GRANT, WRITE_OUT, DATA_OUT
  );
  modport slave (
    output WRITE_REQ, HOLD_REQ, DATA_IN, BURST_LIMIT, READY_OUT,
    input  READ_GRANT, WRITE_OUT, DATA_OUT
  );
endinterface

// File: rtl/wrr_fifo_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: next requester after the last owner.
module wrr_rr_pick import monopix_arb_pkg::*; #(
  parameter int WIDTH = 7,
  parameter int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req,
  input  logic [IW-1:0]    last,
  output logic             valid,
  output logic [IW-1:0]    idx
);
  rr_pick_t p;

  always_comb p = rr_pick(RR_MAX'(req), RR_IW'(last), WIDTH);

  assign valid = p.valid;
  assign idx   = p.idx[IW-1:0];
endmodule

// File: rtl/wrr_fifo_arbiter.sv
// Weighted round-robin merge of source FIFOs into one output stream.
// Optional WRR_ARB_STAT_EN adds per-source popped-word counters (STAT_SEL/STAT_CNT).
module wrr_fifo_arbiter import monopix_arb_pkg::*; #(
  parameter int WIDTH   = 7,
  parameter int DW      = ARB_DW,
  parameter int BURST_W = 4
) (
  input  logic                     BUS_CLK,
  input  logic                     nRST,
`ifdef WRR_ARB_STAT_EN
  input  logic [$clog2(WIDTH)-1:0] STAT_SEL,
  output logic [31:0]              STAT_CNT,
`endif
  wrr_fifo_arbiter_if.master       bus
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state;
  logic [IW-1:0]      owner;
  logic [BURST_W-1:0] burst_cnt;
  logic               pick_vld;
  logic [IW-1:0]      pick_idx;
  logic               own_req, own_hold, pop, at_limit;
  logic [DW-1:0]      own_data;
  logic [WIDTH-1:0]   grant;

  wrr_rr_pick #(.WIDTH(WIDTH), .IW(IW)) u_pick (
    .req   (bus.WRITE_REQ),
    .last  (owner),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  assign own_req  = bus.WRITE_REQ[owner];
  assign own_hold = bus.HOLD_REQ[owner];
  assign own_data = bus.DATA_IN[owner];
  assign pop      = (state == ST_GRANT) && own_req && bus.READY_OUT;
  // >= so a limit lowered mid-burst still ends the burst on the next pop
  assign at_limit = burst_cnt >= bus.BURST_LIMIT[owner];

  always_comb begin
    grant = '0;
    if (pop) grant[owner] = 1'b1;
  end
  assign bus.READ_GRANT = grant;

  always_ff @(posedge BUS_CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= ST_ARB;
      owner     <= IW'(WIDTH - 1);
      burst_cnt <= '0;
    end else if (state == ST_ARB) begin
      if (pick_vld) begin
        owner     <= pick_idx;
        burst_cnt <= '0;
        state     <= ST_GRANT;
      end
    end else begin
      if (pop && !(&burst_cnt)) burst_cnt <= burst_cnt + 1'b1;
      if ((pop && at_limit && !own_hold) || (!own_req && !own_hold))
        state <= ST_ARB;
    end
  end

  always_ff @(posedge BUS_CLK or negedge nRST) begin
    if (!nRST) begin
      bus.WRITE_OUT <= 1'b0;
      bus.DATA_OUT  <= '0;
    end else begin
      bus.WRITE_OUT <= pop;
      if (pop) bus.DATA_OUT <= own_data;
    end
  end

`ifdef WRR_ARB_STAT_EN
  logic [WIDTH-1:0][31:0] stat_cnt;

  always_ff @(posedge BUS_CLK or negedge nRST) begin
    if (!nRST) begin
      stat_cnt <= '0;
      STAT_CNT <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++)
        if (grant[i] && !(&stat_cnt[i])) stat_cnt[i] <= stat_cnt[i] + 1'b1;
      STAT_CNT <= (32'(STAT_SEL) < WIDTH) ? stat_cnt[STAT_SEL] : '0;
    end
  end
`endif

endmodule

// File: tb/tb_wrr_fifo_arbiter.sv
// Self-checking bench for wrr_fifo_arbiter: queue-based source model plus directed scenarios.
module tb_wrr_fifo_arbiter;
  localparam int W  = 7;
  localparam int DW = 32;
  localparam int BW = 4;

  logic BUS_CLK = 1'b0;
  logic nRST;
  always #5 BUS_CLK = ~BUS_CLK;

  wrr_fifo_arbiter_if #(.WIDTH(W), .DW(DW), .BURST_W(BW)) bus();

`ifdef WRR_ARB_STAT_EN
  logic [2:0]  STAT_SEL;
  logic [31:0] STAT_CNT;
`endif

  wrr_fifo_arbiter #(.WIDTH(W), .DW(DW), .BURST_W(BW)) dut (
    .BUS_CLK  (BUS_CLK),
    .nRST     (nRST),
`ifdef WRR_ARB_STAT_EN
    .STAT_SEL (STAT_SEL),
    .STAT_CNT (STAT_CNT),
`endif
    .bus      (bus)
  );

  // source FIFOs: word = {source, sequence}
  logic [DW-1:0] q[W][$];
  int            seq[W];
  logic [W-1:0]  gate, hold_v;
  logic          ready_v;
  logic [W-1:0][BW-1:0] lim_v;

  // reference model state
  bit            m_grant;
  int            m_owner, m_cnt;
  bit            exp_wo;
  logic [DW-1:0] exp_do;
  int            pop_src[$];
  logic [W-1:0]  g_seen;
  logic          wo_seen;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] t1g[8] = '{7'h00, 7'h01, 7'h00, 7'h04, 7'h00, 7'h01, 7'h00, 7'h04};
  logic         t1w[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int s, input int n);
    for (int k = 0; k < n; k++) begin
      q[s].push_back({8'(s), 24'(seq[s])});
      seq[s]++;
    end
  endtask

  function automatic int left_total();
    int t = 0;
    for (int i = 0; i < W; i++) t += q[i].size();
    return t;
  endfunction

  task automatic model_reset();
    m_grant = 1'b0;
    m_owner = W - 1;
    m_cnt   = 0;
    exp_wo  = 1'b0;
    exp_do  = '0;
  endtask

  task automatic drive();
    for (int i = 0; i < W; i++) begin
      bus.WRITE_REQ[i] = gate[i] && (q[i].size() != 0);
      bus.DATA_IN[i]   = (q[i].size() != 0) ? q[i][0] : '0;
    end
    bus.HOLD_REQ    = hold_v;
    bus.READY_OUT   = ready_v;
    bus.BURST_LIMIT = lim_v;
  endtask

  // one clock: drive after posedge, check and advance the model at negedge
  task automatic cycle();
    logic [W-1:0] eg;
    bit pop, found;
    drive();
    @(negedge BUS_CLK);
    eg  = '0;
    pop = 1'b0;
    if (m_grant && bus.WRITE_REQ[m_owner] && bus.READY_OUT) begin
      pop = 1'b1;
      eg[m_owner] = 1'b1;
    end
    chk("grant", bus.READ_GRANT, eg);
    chk("write_out", bus.WRITE_OUT, exp_wo);
    if (exp_wo) chk("data_out", bus.DATA_OUT, exp_do);
    g_seen  = bus.READ_GRANT;
    wo_seen = bus.WRITE_OUT;
    exp_wo = pop;
    if (pop) begin
      exp_do = q[m_owner].pop_front();
      pop_src.push_back(m_owner);
    end
    if (!m_grant) begin
      found = 1'b0;
      for (int k = 1; k <= W; k++) begin
        if (!found && bus.WRITE_REQ[(m_owner + k) % W]) begin
          found   = 1'b1;
          m_owner = (m_owner + k) % W;
        end
      end
      if (found) begin
        m_grant = 1'b1;
        m_cnt   = 0;
      end
    end else if (pop) begin
      // this pop is word m_cnt+1 of the burst
      if (m_cnt >= int'(lim_v[m_owner]) && !bus.HOLD_REQ[m_owner]) m_grant = 1'b0;
      m_cnt++;
    end else if (!bus.WRITE_REQ[m_owner] && !bus.HOLD_REQ[m_owner]) begin
      m_grant = 1'b0;
    end
    @(posedge BUS_CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    #1;
    chk("rst_grant", bus.READ_GRANT, '0);
    chk("rst_write_out", bus.WRITE_OUT, 1'b0);
    chk("rst_data_out", bus.DATA_OUT, '0);
    model_reset();
    @(posedge BUS_CLK);
    #1;
    nRST = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap, done3;
    bit gap_on, prev_ready;
    for (int i = 0; i < W; i++) seq[i] = 0;
    gate = '0; hold_v = '0; ready_v = 1'b1; lim_v = '0;
`ifdef WRR_ARB_STAT_EN
    STAT_SEL = '0;
`endif
    nRST = 1'b0;
    drive();
    model_reset();
    @(posedge BUS_CLK); #1;
    do_reset();

    // T1: sources 0 and 2, single-word bursts, dead cycle between grants
    push(0, 2); push(2, 2); gate = 7'b0000101;
    for (int c = 0; c < 8; c++) begin
      cycle();
      chk("t1_grant", g_seen, t1g[c]);
      chk("t1_write_out", wo_seen, t1w[c]);
    end

    // T2: 4-word bursts of source 4 interleaved with single words of source 1
    pop_src.delete(); push(4, 20); push(1, 5); gate = '1; lim_v[4] = 4'd3;
    for (int c = 0; c < 200 && left_total() != 0; c++) cycle();
    repeat (3) cycle();
    chk("t2_len", pop_src.size(), 25);
    for (int k = 0; k < 25 && k < pop_src.size(); k++)
      chk("t2_src", pop_src[k], ((k % 5) < 4) ? 4 : 1);

    // T3: held 6-word packet on source 3 with a 5-cycle request gap
    lim_v = '0; pop_src.delete(); push(3, 6); push(5, 3); gate = 7'b0101000; gap = 0;
    for (int c = 0; c < 100 && left_total() != 0; c++) begin
      done3  = 6 - q[3].size();
      gap_on = (done3 >= 3) && (gap < 5);
      gate[3]   = !gap_on;
      hold_v[3] = done3 < 6;
      cycle();
      if (gap_on) begin
        gap++;
        chk("t3_gap_grant", g_seen, '0);
      end
    end
    repeat (3) cycle();
    chk("t3_gap_len", gap, 5);
    chk("t3_len", pop_src.size(), 9);
    for (int k = 0; k < 6 && k < pop_src.size(); k++) chk("t3_src", pop_src[k], 3);

    // T4: READY_OUT toggling during a burst
    hold_v = '0; lim_v = '1; pop_src.delete(); push(0, 8); gate = 7'b0000001; prev_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      ready_v = (c % 2) == 0;
      cycle();
      if (!ready_v) chk("t4_grant_not_ready", g_seen, '0);
      if (!prev_ready) chk("t4_after_fall", wo_seen, 1'b0);
      prev_ready = ready_v;
    end
    ready_v = 1'b1;
    chk("t4_drained", q[0].size(), 0);

    // T5: reset mid-burst on source 6, then scan restarts at index 0
    pop_src.delete(); push(6, 12); gate = 7'b1000000;
    for (int c = 0; c < 20 && pop_src.size() < 4; c++) cycle();
    push(2, 3); push(4, 3);
    do_reset();
    gate = '1;
    cycle();
    chk("t5_dead", g_seen, '0);
    cycle();
    chk("t5_first", g_seen, 7'b0000100);

    // random traffic with gaps, holds, backpressure and limit changes
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(4, 0) == 0) push($urandom_range(W - 1, 0), $urandom_range(4, 1));
      for (int i = 0; i < W; i++) begin
        gate[i]   = $urandom_range(9, 0) != 0;
        hold_v[i] = $urandom_range(49, 0) == 0;
      end
      ready_v = $urandom_range(3, 0) != 0;
      if (c % 250 == 0)
        for (int i = 0; i < W; i++) lim_v[i] = BW'($urandom_range(5, 0));
      cycle();
    end
    gate = '1; hold_v = '0; ready_v = 1'b1;
    for (int c = 0; c < 3000 && left_total() != 0; c++) cycle();
    repeat (4) cycle();
    chk("drain_left", left_total(), 0);

`ifdef WRR_ARB_STAT_EN
    // T6: popped-word counters
    do_reset();
    push(0, 100); push(5, 37);
    for (int i = 0; i < W; i++) lim_v[i] = BW'($urandom_range(7, 0));
    for (int c = 0; c < 600 && left_total() != 0; c++) cycle();
    repeat (3) cycle();
    STAT_SEL = 3'd0; cycle(); cycle();
    chk("t6_stat0", STAT_CNT, 100);
    STAT_SEL = 3'd5; cycle(); cycle();
    chk("t6_stat5", STAT_CNT, 37);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
